decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction decoder.
- Accepts the instruction byte stream from the fetch unit one word per beat and assembles multi-word instructions (opcode plus immediate words for LDI/JMP/CALL).
- Emits one fully decoded micro-op per instruction to the execute stage over a valid/ready interface, with halt-latching and flush.
- Sits between fetch and register-file/ALU control.

Parameters:
- DW, 8, instruction/immediate word width; field extraction uses the low 8 bits.
- RW, 3, register address width; operands zero-extended to RW.
- IMM_WORDS, 1, immediate words following LDI/JMP/CALL (1..4).
- ALUW, 4, ALU mode width (extended ALU set).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous flush from the branch/redirect logic.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  decoder accepts the word this cycle.
- in_word  in  DW  instruction or immediate word.
- out_valid  out  1  decoded micro-op valid.
- out_ready  in  1  execute consumes the micro-op.
- out_opcode  out  8  `OP_* code; raw word if illegal.
- out_alu_mode  out  ALUW  ALU mode.
- out_iaddr  out  RW  write-back register.
- out_iaddr_en  out  1  write-back used.
- out_oaddr  out  RW  read register.
- out_oaddr_en  out  1  read used.
- out_imm  out  IMM_WORDS*DW  assembled immediate, little-endian.
- out_has_imm  out  1  out_imm meaningful.
- out_illegal  out  1  word matched no `PATTERN_*.
- halted  out  1  HLT emitted; input stalled.

Behaviour:
- Reset (rst_n low, async): state=S_OPC, imm counter=0, halted=0, out_valid=0, all out_* data fields 0. Outputs never carry X.
- Accept: a word is accepted when in_valid && in_ready, where in_ready = !halted && (!out_valid || out_ready).
- S_OPC: classify the accepted word with the shared `PATTERN_*` casez priority (NOP, HLT, CALL, RET, CMP, ALU, LDI, LDX, STX, PUSH, POP, JMP, MOV).
  - LDI/JMP/CALL: latch the decoded fields, clear out_imm, go to S_IMM with count=0.
  - Otherwise: load the output register and set out_valid next cycle (latency 1 cycle from acceptance).
- S_IMM: each accepted word goes to out_imm[count*DW +: DW].
  - On count==IMM_WORDS-1: load the output register, set out_valid, return to S_OPC.
  - Otherwise count++.
  - Pending in_valid gaps simply wait; the state is held.
- Field rules (op1=word[5:3], op2=word[2:0]):
  - MOV: iaddr=op1, oaddr=op2.
  - LDI, LDX, POP: iaddr=op2.
  - STX, PUSH: oaddr=op2.
  - ALU: iaddr=`REG_A, alu_mode={op2[2],op1}.
  - CMP: alu_mode=`ALU_SUB zero-extended.
  - CALL: iaddr=oaddr=`REG_H.
  - The matching _en is 1 only where a rule applies; unused fields are 0.
- Illegal: out_opcode=raw word, out_illegal=1, all _en=0, single-word.
- Output hold: while out_valid && !out_ready, all out_* are stable. When out_ready is high, a new micro-op may load the same cycle, giving back-to-back throughput of 1 single-word instruction per cycle.
- HLT: when an HLT micro-op loads, halted=1 on the next edge. in_ready stays 0 until flush or reset; the HLT micro-op itself is still delivered.
- Flush: highest priority over acceptance.
  - Next edge: out_valid=0, state=S_OPC, count=0, halted=0.
  - Partial immediate assembly is discarded.
  - A word presented during the flush cycle is not accepted (in_ready forced 0 that cycle).
- Reset mid-instruction: partial state is discarded immediately (async).

Decomposition:
- Shared symbols header (existing): `PATTERN_*`, `OP_*`, `REG_A`, `REG_H`, `ALU_*`.
- Add to it: state encodings S_OPC/S_IMM and an `ALUW`-sized `ALU_SUB` form.
- Sub-module: decode_fields, purely combinational, mapping a word to {opcode, alu_mode, iaddr/_en, oaddr/_en, needs_imm, illegal}. It replaces the old combinational decoder.
- decode_stage holds the FSM, immediate counter, output register and halt latch.

Test Plan:
- After reset, feed MOV word with op1=3'd2, op2=3'd5, out_ready=1 -> next cycle out_valid=1, opcode=`OP_MOV, iaddr=2, oaddr=5, both _en=1, has_imm=0.
- LDI op2=3'd4, then 8'h3C two cycles later (in_valid low between) -> single micro-op after the 8'h3C is accepted: iaddr=4, out_imm=8'h3C, has_imm=1. No output after the opcode word alone.
- Three single-word ALU instructions with out_ready=0 for 3 cycles, then 1 -> first micro-op held stable, in_ready=0 while full, then all three delivered in order on consecutive cycles.
- IMM_WORDS=2: CALL, 8'h34, 8'h12 -> out_imm=16'h1234, iaddr=oaddr=`REG_H.
- LDI accepted, flush asserted before the immediate -> out_valid stays 0; the next word is decoded as an opcode.
- HLT then NOP offered -> HLT delivered, halted=1, NOP not accepted. After flush, NOP is accepted and decoded.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decoder symbols: instruction patterns, micro-op codes, register and
// ALU constants, and the decode FSM state encoding.
package decode_stage_pkg;

  // A pattern matches when the word's cared-about bits equal val.
  typedef struct packed {
    logic [7:0] care;
    logic [7:0] val;
  } pattern_t;

  // Patterns are tested in this order; first hit wins.
  localparam pattern_t PATTERN_NOP  = '{care: 8'hFF, val: 8'h00};
  localparam pattern_t PATTERN_HLT  = '{care: 8'hFF, val: 8'h01};
  localparam pattern_t PATTERN_CALL = '{care: 8'hFF, val: 8'h02};
  localparam pattern_t PATTERN_RET  = '{care: 8'hFF, val: 8'h03};
  localparam pattern_t PATTERN_CMP  = '{care: 8'hFF, val: 8'h04};
  localparam pattern_t PATTERN_ALU  = '{care: 8'hC3, val: 8'h80}; // 10 mmm m 00
  localparam pattern_t PATTERN_LDI  = '{care: 8'hF8, val: 8'h10};
  localparam pattern_t PATTERN_LDX  = '{care: 8'hF8, val: 8'h18};
  localparam pattern_t PATTERN_STX  = '{care: 8'hF8, val: 8'h20};
  localparam pattern_t PATTERN_PUSH = '{care: 8'hF8, val: 8'h28};
  localparam pattern_t PATTERN_POP  = '{care: 8'hF8, val: 8'h30};
  localparam pattern_t PATTERN_JMP  = '{care: 8'hFF, val: 8'h38};
  localparam pattern_t PATTERN_MOV  = '{care: 8'hC0, val: 8'h40}; // 01 ddd sss

  localparam logic [7:0] OP_NOP  = 8'd0;
  localparam logic [7:0] OP_HLT  = 8'd1;
  localparam logic [7:0] OP_CALL = 8'd2;
  localparam logic [7:0] OP_RET  = 8'd3;
  localparam logic [7:0] OP_CMP  = 8'd4;
  localparam logic [7:0] OP_ALU  = 8'd5;
  localparam logic [7:0] OP_LDI  = 8'd6;
  localparam logic [7:0] OP_LDX  = 8'd7;
  localparam logic [7:0] OP_STX  = 8'd8;
  localparam logic [7:0] OP_PUSH = 8'd9;
  localparam logic [7:0] OP_POP  = 8'd10;
  localparam logic [7:0] OP_JMP  = 8'd11;
  localparam logic [7:0] OP_MOV  = 8'd12;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_H = 3'd7;

  // Legacy 3-bit ALU codes.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // ALU_SUB widened to the extended 4-bit mode field.
  localparam logic [3:0] ALU_SUB_W = {1'b0, ALU_SUB};

  typedef enum logic {
    S_OPC = 1'b0,
    S_IMM = 1'b1
  } state_t;

  function automatic logic pat_hit(input logic [7:0] w, input pattern_t p);
    return (w & p.care) == p.val;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
interface decode_stage_if #(
  parameter int DW        = 8,
  parameter int RW        = 3,
  parameter int IMM_WORDS = 1,
  parameter int ALUW      = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_word;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_opcode;
  logic [ALUW-1:0]         out_alu_mode;
  logic [RW-1:0]           out_iaddr;
  logic                    out_iaddr_en;
  logic [RW-1:0]           out_oaddr;
  logic                    out_oaddr_en;
  logic [IMM_WORDS*DW-1:0] out_imm;
  logic                    out_has_imm;
  logic                    out_illegal;
  logic                    halted;

  // Decoder side.
  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_opcode, out_alu_mode, out_iaddr,
           out_iaddr_en, out_oaddr, out_oaddr_en, out_imm, out_has_imm,
           out_illegal, halted
  );

  // Fetch / execute side.
  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_opcode, out_alu_mode, out_iaddr,
           out_iaddr_en, out_oaddr, out_oaddr_en, out_imm, out_has_imm,
           out_illegal, halted
  );
endinterface

// File: rtl/decode_stage_fields.sv
// Combinational field decode of one instruction word (low 8 bits).
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int DW   = 8,
  parameter int RW   = 3,
  parameter int ALUW = 4
) (
  input  logic [DW-1:0]   word,
  output logic [7:0]      opcode,
  output logic [ALUW-1:0] alu_mode,
  output logic [RW-1:0]   iaddr,
  output logic            iaddr_en,
  output logic [RW-1:0]   oaddr,
  output logic            oaddr_en,
  output logic            needs_imm,
  output logic            illegal
);
  logic [7:0]    w8;
  logic [RW-1:0] op1, op2;

  assign w8  = word[7:0];
  assign op1 = RW'(w8[5:3]);
  assign op2 = RW'(w8[2:0]);

  // Priority classification; unused fields stay zero.
  always_comb begin
    opcode    = w8;
    alu_mode  = '0;
    iaddr     = '0;
    iaddr_en  = 1'b0;
    oaddr     = '0;
    oaddr_en  = 1'b0;
    needs_imm = 1'b0;
    illegal   = 1'b0;
    if (pat_hit(w8, PATTERN_NOP)) begin
      opcode = OP_NOP;
    end else if (pat_hit(w8, PATTERN_HLT)) begin
      opcode = OP_HLT;
    end else if (pat_hit(w8, PATTERN_CALL)) begin
      opcode    = OP_CALL;
      iaddr     = RW'(REG_H);
      iaddr_en  = 1'b1;
      oaddr     = RW'(REG_H);
      oaddr_en  = 1'b1;
      needs_imm = 1'b1;
    end else if (pat_hit(w8, PATTERN_RET)) begin
      opcode = OP_RET;
    end else if (pat_hit(w8, PATTERN_CMP)) begin
      opcode   = OP_CMP;
      alu_mode = ALUW'(ALU_SUB_W);
    end else if (pat_hit(w8, PATTERN_ALU)) begin
      opcode   = OP_ALU;
      alu_mode = ALUW'({w8[2], w8[5:3]});
      iaddr    = RW'(REG_A);
      iaddr_en = 1'b1;
    end else if (pat_hit(w8, PATTERN_LDI)) begin
      opcode    = OP_LDI;
      iaddr     = op2;
      iaddr_en  = 1'b1;
      needs_imm = 1'b1;
    end else if (pat_hit(w8, PATTERN_LDX)) begin
      opcode   = OP_LDX;
      iaddr    = op2;
      iaddr_en = 1'b1;
    end else if (pat_hit(w8, PATTERN_STX)) begin
      opcode   = OP_STX;
      oaddr    = op2;
      oaddr_en = 1'b1;
    end else if (pat_hit(w8, PATTERN_PUSH)) begin
      opcode   = OP_PUSH;
      oaddr    = op2;
      oaddr_en = 1'b1;
    end else if (pat_hit(w8, PATTERN_POP)) begin
      opcode   = OP_POP;
      iaddr    = op2;
      iaddr_en = 1'b1;
    end else if (pat_hit(w8, PATTERN_JMP)) begin
      opcode    = OP_JMP;
      needs_imm = 1'b1;
    end else if (pat_hit(w8, PATTERN_MOV)) begin
      opcode   = OP_MOV;
      iaddr    = op1;
      iaddr_en = 1'b1;
      oaddr    = op2;
      oaddr_en = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: assembles opcode + immediate words from fetch and
// presents one decoded micro-op at a time to execute, with halt and flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DW        = 8,
  parameter int RW        = 3,
  parameter int IMM_WORDS = 1,
  parameter int ALUW      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  decode_stage_if.slave bus
);
  localparam int CW = (IMM_WORDS > 1) ? $clog2(IMM_WORDS) : 1;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    acc, last_imm;
  logic                    ld_fields, ld_uop, imm_wr, hlt_set;

  logic                    out_valid, halted, out_iaddr_en, out_oaddr_en;
  logic                    out_has_imm, out_illegal;
  logic [7:0]              out_opcode;
  logic [ALUW-1:0]         out_alu_mode;
  logic [RW-1:0]           out_iaddr, out_oaddr;
  logic [IMM_WORDS*DW-1:0] out_imm;

  logic [7:0]              d_opcode;
  logic [ALUW-1:0]         d_alu_mode;
  logic [RW-1:0]           d_iaddr, d_oaddr;
  logic                    d_iaddr_en, d_oaddr_en, d_needs_imm, d_illegal;

  decode_fields #(.DW(DW), .RW(RW), .ALUW(ALUW)) u_fields (
    .word      (bus.in_word),
    .opcode    (d_opcode),
    .alu_mode  (d_alu_mode),
    .iaddr     (d_iaddr),
    .iaddr_en  (d_iaddr_en),
    .oaddr     (d_oaddr),
    .oaddr_en  (d_oaddr_en),
    .needs_imm (d_needs_imm),
    .illegal   (d_illegal)
  );

  // Flush blocks acceptance in its own cycle; the output slot must be free
  // or draining for any word to enter.
  assign bus.in_ready = !halted && (!out_valid || bus.out_ready) && !flush;
  assign acc          = bus.in_valid && bus.in_ready;
  assign last_imm     = (cnt == CW'(IMM_WORDS - 1));
  assign hlt_set      = ld_uop && (state == S_OPC) && !d_illegal &&
                        (d_opcode == OP_HLT);

  // State and immediate counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OPC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic and datapath load strobes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ld_fields = 1'b0;
    ld_uop    = 1'b0;
    imm_wr    = 1'b0;
    if (flush) begin
      state_n = S_OPC;
      cnt_n   = '0;
    end else if (acc) begin
      case (state)
        S_OPC: begin
          ld_fields = 1'b1;
          if (d_needs_imm) begin
            state_n = S_IMM;
            cnt_n   = '0;
          end else begin
            ld_uop = 1'b1;
          end
        end
        S_IMM: begin
          imm_wr = 1'b1;
          if (last_imm) begin
            ld_uop  = 1'b1;
            state_n = S_OPC;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = S_OPC;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output register, immediate assembly and halt latch. Fields of an
  // immediate-carrying op are parked in the output register while out_valid
  // is low, since acceptance of the opcode already drained the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      halted       <= 1'b0;
      out_opcode   <= '0;
      out_alu_mode <= '0;
      out_iaddr    <= '0;
      out_iaddr_en <= 1'b0;
      out_oaddr    <= '0;
      out_oaddr_en <= 1'b0;
      out_imm      <= '0;
      out_has_imm  <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      if (flush)              out_valid <= 1'b0;
      else if (ld_uop)        out_valid <= 1'b1;
      else if (bus.out_ready) out_valid <= 1'b0;

      if (flush)        halted <= 1'b0;
      else if (hlt_set) halted <= 1'b1;

      if (ld_fields) begin
        out_opcode   <= d_opcode;
        out_alu_mode <= d_alu_mode;
        out_iaddr    <= d_iaddr;
        out_iaddr_en <= d_iaddr_en;
        out_oaddr    <= d_oaddr;
        out_oaddr_en <= d_oaddr_en;
        out_has_imm  <= d_needs_imm;
        out_illegal  <= d_illegal;
        out_imm      <= '0;
      end

      if (imm_wr) begin
        for (int i = 0; i < IMM_WORDS; i++) begin
          if (cnt == CW'(i)) out_imm[i*DW +: DW] <= bus.in_word;
        end
      end
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.halted       = halted;
  assign bus.out_opcode   = out_opcode;
  assign bus.out_alu_mode = out_alu_mode;
  assign bus.out_iaddr    = out_iaddr;
  assign bus.out_iaddr_en = out_iaddr_en;
  assign bus.out_oaddr    = out_oaddr;
  assign bus.out_oaddr_en = out_oaddr_en;
  assign bus.out_imm      = out_imm;
  assign bus.out_has_imm  = out_has_imm;
  assign bus.out_illegal  = out_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with 1 immediate word, one
// with 2.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush2 = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.DW(8), .RW(3), .IMM_WORDS(1), .ALUW(4)) b1 ();
  decode_stage_if #(.DW(8), .RW(3), .IMM_WORDS(2), .ALUW(4)) b2 ();

  decode_stage #(.DW(8), .RW(3), .IMM_WORDS(1), .ALUW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1));
  decode_stage #(.DW(8), .RW(3), .IMM_WORDS(2), .ALUW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(b2));

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] op;
    logic [3:0] alu;
    logic [2:0] ia;
    logic       ie;
    logic [2:0] oa;
    logic       oe;
    logic       ill;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // word, opcode, alu, iaddr, ien, oaddr, oen, illegal
    vt[0] = {8'h04, 8'd4,  4'h1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // CMP
    vt[1] = {8'h2B, 8'd9,  4'h0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0}; // PUSH r3
    vt[2] = {8'h36, 8'd10, 4'h0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0}; // POP r6
    vt[3] = {8'h1D, 8'd7,  4'h0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0}; // LDX r5
    vt[4] = {8'h03, 8'd3,  4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // RET
    vt[5] = {8'hFF, 8'hFF, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1}; // illegal

    b1.in_valid = 0; b1.in_word = 0; b1.out_ready = 0;
    b2.in_valid = 0; b2.in_word = 0; b2.out_ready = 0;

    // Reset state
    #2;
    check("rst.valid", b1.out_valid, 0);
    check("rst.halted", b1.halted, 0);
    check("rst.opcode", b1.out_opcode, 0);
    check("rst.imm", b1.out_imm, 0);
    #10 rst_n = 1'b1;
    tick();
    check("rst.in_ready", b1.in_ready, 1);

    // MOV r2 <- r5
    b1.out_ready = 1; b1.in_valid = 1; b1.in_word = 8'h55;
    tick();
    b1.in_valid = 0;
    check("mov.valid", b1.out_valid, 1);
    check("mov.opcode", b1.out_opcode, 8'd12);
    check("mov.iaddr", b1.out_iaddr, 2);
    check("mov.oaddr", b1.out_oaddr, 5);
    check("mov.ens", {b1.out_iaddr_en, b1.out_oaddr_en}, 2'b11);
    check("mov.has_imm", b1.out_has_imm, 0);
    tick();
    check("mov.drained", b1.out_valid, 0);

    // LDI r4, 0x3C with a gap before the immediate
    b1.in_valid = 1; b1.in_word = 8'h14;
    tick();
    b1.in_valid = 0;
    check("ldi.no_out_opc", b1.out_valid, 0);
    tick();
    check("ldi.no_out_gap", b1.out_valid, 0);
    b1.in_valid = 1; b1.in_word = 8'h3C;
    tick();
    b1.in_valid = 0;
    check("ldi.valid", b1.out_valid, 1);
    check("ldi.opcode", b1.out_opcode, 8'd6);
    check("ldi.iaddr", b1.out_iaddr, 4);
    check("ldi.ens", {b1.out_iaddr_en, b1.out_oaddr_en}, 2'b10);
    check("ldi.imm", b1.out_imm, 8'h3C);
    check("ldi.has_imm", b1.out_has_imm, 1);
    tick();

    // Single-word table, back to back
    for (int i = 0; i < 6; i++) begin
      b1.in_valid = 1; b1.in_word = vt[i].w;
      tick();
      check($sformatf("vec%0d.valid", i), b1.out_valid, 1);
      check($sformatf("vec%0d.op", i), b1.out_opcode, vt[i].op);
      check($sformatf("vec%0d.alu", i), b1.out_alu_mode, vt[i].alu);
      check($sformatf("vec%0d.iaddr", i), {b1.out_iaddr, b1.out_iaddr_en}, {vt[i].ia, vt[i].ie});
      check($sformatf("vec%0d.oaddr", i), {b1.out_oaddr, b1.out_oaddr_en}, {vt[i].oa, vt[i].oe});
      check($sformatf("vec%0d.ill", i), {b1.out_illegal, b1.out_has_imm}, {vt[i].ill, 1'b0});
    end
    b1.in_valid = 0;
    tick();

    // Backpressure: three ALU ops, execute stalled for 3 cycles
    b1.out_ready = 0; b1.in_valid = 1; b1.in_word = 8'h9C;
    tick();
    b1.in_word = 8'hA8;
    check("bp.valid0", b1.out_valid, 1);
    check("bp.op0", b1.out_opcode, 8'd5);
    check("bp.alu0", b1.out_alu_mode, 4'hB);
    check("bp.ia0", {b1.out_iaddr, b1.out_iaddr_en}, {3'd0, 1'b1});
    check("bp.in_ready0", b1.in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("bp.hold%0d.valid", i), b1.out_valid, 1);
      check($sformatf("bp.hold%0d.alu", i), b1.out_alu_mode, 4'hB);
      check($sformatf("bp.hold%0d.in_ready", i), b1.in_ready, 0);
    end
    b1.out_ready = 1;
    #1;
    check("bp.in_ready_rel", b1.in_ready, 1);
    tick();
    b1.in_word = 8'h84;
    check("bp.valid1", b1.out_valid, 1);
    check("bp.alu1", b1.out_alu_mode, 4'h5);
    tick();
    b1.in_valid = 0;
    check("bp.valid2", b1.out_valid, 1);
    check("bp.alu2", b1.out_alu_mode, 4'h8);
    tick();
    check("bp.drained", b1.out_valid, 0);

    // Flush during immediate assembly
    b1.in_valid = 1; b1.in_word = 8'h14;
    tick();
    flush = 1; b1.in_word = 8'h3C;
    #1;
    check("fl.in_ready", b1.in_ready, 0);
    tick();
    flush = 0;
    check("fl.valid", b1.out_valid, 0);
    tick();
    b1.in_valid = 0;
    check("fl.valid_after", b1.out_valid, 1);
    check("fl.opcode", b1.out_opcode, 8'h3C);
    check("fl.illegal", b1.out_illegal, 1);
    check("fl.has_imm", b1.out_has_imm, 0);
    check("fl.ens", {b1.out_iaddr_en, b1.out_oaddr_en}, 2'b00);
    tick();

    // HLT then NOP
    b1.in_valid = 1; b1.in_word = 8'h01;
    tick();
    b1.in_word = 8'h00;
    check("hlt.valid", b1.out_valid, 1);
    check("hlt.opcode", b1.out_opcode, 8'd1);
    check("hlt.halted", b1.halted, 1);
    check("hlt.in_ready", b1.in_ready, 0);
    tick();
    check("hlt.nop_blocked", b1.out_valid, 0);
    tick();
    check("hlt.still_halted", b1.halted, 1);
    check("hlt.still_blocked", b1.out_valid, 0);
    flush = 1;
    tick();
    flush = 0;
    #1;
    check("hlt.unhalted", b1.halted, 0);
    check("hlt.in_ready_back", b1.in_ready, 1);
    tick();
    b1.in_valid = 0;
    check("hlt.nop_valid", b1.out_valid, 1);
    check("hlt.nop_opcode", b1.out_opcode, 8'd0);
    check("hlt.nop_ill", b1.out_illegal, 0);
    tick();

    // Two-word immediate: CALL 0x1234
    b2.out_ready = 1; b2.in_valid = 1; b2.in_word = 8'h02;
    tick();
    b2.in_word = 8'h34;
    check("call.no_out0", b2.out_valid, 0);
    tick();
    b2.in_word = 8'h12;
    check("call.no_out1", b2.out_valid, 0);
    tick();
    b2.in_valid = 0;
    check("call.valid", b2.out_valid, 1);
    check("call.opcode", b2.out_opcode, 8'd2);
    check("call.imm", b2.out_imm, 16'h1234);
    check("call.addrs", {b2.out_iaddr, b2.out_oaddr}, {3'd7, 3'd7});
    check("call.ens", {b2.out_iaddr_en, b2.out_oaddr_en, b2.out_has_imm}, 3'b111);
    tick();

    // Asynchronous reset in the middle of an LDI
    b1.in_valid = 1; b1.in_word = 8'h14;
    tick();
    b1.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.opcode", b1.out_opcode, 0);
    check("arst.has_imm", b1.out_has_imm, 0);
    #1 rst_n = 1'b1;
    b1.in_valid = 1; b1.in_word = 8'h55;
    tick();
    b1.in_valid = 0;
    check("arst.valid", b1.out_valid, 1);
    check("arst.opcode_mov", b1.out_opcode, 8'd12);
    check("arst.has_imm_mov", b1.out_has_imm, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
